// File: rtl/decode_stage_pipe_if.sv
// Fetch/decode/execute handshake and control bundle for decode_stage_pipe.
// slave = decode stage view, master = surrounding pipeline (or testbench) view.
interface decode_stage_pipe_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             if_valid;
    logic [31:0]      if_inst;
    logic [XLEN-1:0]  if_pc;
    logic             id_ready;
    logic             flush;
    logic             ex_ready;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [4:0]       ex_rd;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [2:0]       ex_funct3;
    logic [XLEN-1:0]  ex_imm;
    logic [4:0]       ex_alu_sel;
    logic             ex_b_sel;
    logic             ex_pc_a_sel;
    logic [1:0]       ex_wb_sel;
    logic             ex_reg_we;
    logic             ex_mem_we;
    logic             ex_mem_re;
    logic             ex_is_branch;
    logic             ex_is_jump;
    logic             ex_illegal;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    modport slave (
        input  if_valid, if_inst, if_pc, flush, ex_ready,
        output id_ready, ex_valid, ex_pc, ex_rd, ex_rs1, ex_rs2, ex_funct3, ex_imm,
               ex_alu_sel, ex_b_sel, ex_pc_a_sel, ex_wb_sel, ex_reg_we, ex_mem_we,
               ex_mem_re, ex_is_branch, ex_is_jump, ex_illegal, stall_cnt, bubble_cnt
    );

    modport master (
        output if_valid, if_inst, if_pc, flush, ex_ready,
        input  id_ready, ex_valid, ex_pc, ex_rd, ex_rs1, ex_rs2, ex_funct3, ex_imm,
               ex_alu_sel, ex_b_sel, ex_pc_a_sel, ex_wb_sel, ex_reg_we, ex_mem_we,
               ex_mem_re, ex_is_branch, ex_is_jump, ex_illegal, stall_cnt, bubble_cnt
    );
endinterface

// File: rtl/decode_stage_pipe.sv
// Registered RV32I/RV64I decode stage with load-use interlock, flush and perf counters.
// Define DECODE_M_EXT_EN to accept OP funct7=0000001 (M extension) instead of flagging it illegal.
module decode_stage_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    decode_stage_pipe_if.slave bus
);
`ifdef DECODE_M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic {ST_RUN, ST_BUBBLE} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [XLEN-1:0] imm;
        logic [4:0]      alu_sel;
        logic            b_sel;
        logic            pc_a_sel;
        logic [1:0]      wb_sel;
        logic            reg_we;
        logic            mem_we;
        logic            mem_re;
        logic            is_branch;
        logic            is_jump;
        logic            illegal;
    } ctrl_t;

    logic [31:0]     inst;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic            is_mul;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    ctrl_t           dec;

    assign inst   = bus.if_inst;
    assign opc    = inst[6:0];
    assign f3     = inst[14:12];
    assign is_mul = (opc == OPC_OP) && (inst[31:25] == 7'b0000001);
    assign imm_i  = XLEN'($signed(inst[31:20]));
    assign imm_s  = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b  = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

    always_comb begin
        dec        = '0;
        dec.pc     = bus.if_pc;
        dec.funct3 = f3;
        case (opc)
            OPC_LUI: begin
                dec.rd = inst[11:7]; dec.imm = imm_u; dec.b_sel = 1'b1;
                dec.wb_sel = 2'd1; dec.reg_we = 1'b1;
            end
            OPC_AUIPC: begin
                dec.rd = inst[11:7]; dec.imm = imm_u; dec.b_sel = 1'b1; dec.pc_a_sel = 1'b1;
                dec.wb_sel = 2'd1; dec.reg_we = 1'b1;
            end
            OPC_JAL: begin
                dec.rd = inst[11:7]; dec.imm = imm_j; dec.b_sel = 1'b1; dec.pc_a_sel = 1'b1;
                dec.wb_sel = 2'd2; dec.reg_we = 1'b1; dec.is_jump = 1'b1;
            end
            OPC_JALR: begin
                dec.rd = inst[11:7]; dec.rs1 = inst[19:15]; dec.imm = imm_i; dec.b_sel = 1'b1;
                dec.wb_sel = 2'd2; dec.reg_we = 1'b1; dec.is_jump = 1'b1;
            end
            OPC_BRANCH: begin
                dec.rs1 = inst[19:15]; dec.rs2 = inst[24:20]; dec.imm = imm_b;
                dec.b_sel = 1'b1; dec.pc_a_sel = 1'b1; dec.is_branch = 1'b1;
            end
            OPC_LOAD: begin
                dec.rd = inst[11:7]; dec.rs1 = inst[19:15]; dec.imm = imm_i; dec.b_sel = 1'b1;
                dec.wb_sel = 2'd0; dec.reg_we = 1'b1; dec.mem_re = 1'b1;
            end
            OPC_STORE: begin
                dec.rs1 = inst[19:15]; dec.rs2 = inst[24:20]; dec.imm = imm_s;
                dec.b_sel = 1'b1; dec.mem_we = 1'b1;
            end
            OPC_OPIMM: begin
                dec.rd = inst[11:7]; dec.rs1 = inst[19:15]; dec.imm = imm_i; dec.b_sel = 1'b1;
                dec.wb_sel = 2'd1; dec.reg_we = 1'b1;
                // funct7[5] only selects SRA vs SRL on shift-immediates; elsewhere it is imm data
                dec.alu_sel = {1'b0, inst[30] & ((f3 == 3'b001) | (f3 == 3'b101)), f3};
            end
            OPC_OP: begin
                dec.rd = inst[11:7]; dec.rs1 = inst[19:15]; dec.rs2 = inst[24:20];
                dec.wb_sel = 2'd1; dec.reg_we = 1'b1;
                dec.alu_sel = {is_mul, inst[30], f3};
                dec.illegal = is_mul & ~M_EN;
            end
            OPC_FENCE, OPC_SYSTEM: ;
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec         = '0;
            dec.pc      = bus.if_pc;
            dec.funct3  = f3;
            dec.illegal = 1'b1;
        end
    end

    state_t state_reg, state_next;
    logic   ex_valid_reg;
    ctrl_t  ex_reg;
    logic   adv, haz, id_ready, accept, load_bubble;

    assign adv = ~ex_valid_reg | bus.ex_ready;
    // Unused source fields decode as x0, so they can never match a nonzero load rd
    assign haz = bus.if_valid & ex_valid_reg & ex_reg.mem_re & (ex_reg.rd != 5'd0) &
                 ((ex_reg.rd == dec.rs1) | (ex_reg.rd == dec.rs2));

    always_comb begin
        state_next  = state_reg;
        id_ready    = 1'b0;
        load_bubble = 1'b0;
        if (reset) begin
            state_next = ST_RUN;
        end else if (bus.flush) begin
            state_next = ST_RUN;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    id_ready = adv & ~haz;
                    if (adv & haz) begin
                        state_next  = ST_BUBBLE;
                        load_bubble = 1'b1;
                    end
                end
                ST_BUBBLE: begin
                    id_ready = adv;
                    if (adv) state_next = ST_RUN;
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    assign accept = bus.if_valid & id_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_RUN;
            ex_valid_reg <= 1'b0;
            ex_reg       <= '0;
        end else begin
            state_reg <= state_next;
            if (bus.flush) begin
                ex_valid_reg <= 1'b0;
                ex_reg       <= '0;
            end else if (accept) begin
                ex_valid_reg <= 1'b1;
                ex_reg       <= dec;
            end else if (adv) begin
                ex_valid_reg <= 1'b0;
                ex_reg       <= '0;
            end
        end
    end

    logic [1:0]            cnt_inc;
    logic [1:0][CNT_W-1:0] cnt_val;

    assign cnt_inc[0] = bus.if_valid & ~id_ready;
    assign cnt_inc[1] = load_bubble;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clock) begin
                if (reset)
                    cnt_reg <= '0;
                else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}}))
                    cnt_reg <= cnt_reg + CNT_W'(1);
            end
            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    assign bus.id_ready     = id_ready;
    assign bus.ex_valid     = ex_valid_reg;
    assign bus.ex_pc        = ex_reg.pc;
    assign bus.ex_rd        = ex_reg.rd;
    assign bus.ex_rs1       = ex_reg.rs1;
    assign bus.ex_rs2       = ex_reg.rs2;
    assign bus.ex_funct3    = ex_reg.funct3;
    assign bus.ex_imm       = ex_reg.imm;
    assign bus.ex_alu_sel   = ex_reg.alu_sel;
    assign bus.ex_b_sel     = ex_reg.b_sel;
    assign bus.ex_pc_a_sel  = ex_reg.pc_a_sel;
    assign bus.ex_wb_sel    = ex_reg.wb_sel;
    assign bus.ex_reg_we    = ex_reg.reg_we;
    assign bus.ex_mem_we    = ex_reg.mem_we;
    assign bus.ex_mem_re    = ex_reg.mem_re;
    assign bus.ex_is_branch = ex_reg.is_branch;
    assign bus.ex_is_jump   = ex_reg.is_jump;
    assign bus.ex_illegal   = ex_reg.illegal;
    assign bus.stall_cnt    = cnt_val[0];
    assign bus.bubble_cnt   = cnt_val[1];
endmodule
